lif_sweep_scheduler: RTL
========================

Name: lif_sweep_scheduler

Overview:
- Time-multiplexes one leaky-integrate-and-fire (LIF) update datapath across NUM_NEURONS neurons whose state lives in an external single-port synchronous neuron memory.
- Arbitrates that memory between two users: the UART-driven weight loader (load_* port) and the periodic update sweep.
- Owns the tick timer, the sweep FSM, the saturating LIF arithmetic and the spike output vector. Sits between the UART receiver and the neuron memory inside NeuralChip.

Parameters:
- NUM_NEURONS, 8, neurons per sweep (power of two, 2..64)
- ADDR_W, 3, log2(NUM_NEURONS)
- POT_W, 8, width of weight, potential and threshold
- TICK_PERIOD, 64, CLK cycles between sweep starts; must be >= 2*NUM_NEURONS+2
- LEAK, 1, constant subtracted from the potential on every update

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- enable  in  1  tick timer runs only while high
- threshold  in  POT_W  firing threshold, sampled at sweep start
- spike_in  in  NUM_NEURONS  input spikes, sampled at sweep start
- load_valid  in  1  loader write request
- load_addr  in  ADDR_W  neuron index to load
- load_data  in  2*POT_W  {weight, potential} to write
- load_ready  out  1  loader write accepted this cycle when high with load_valid
- mem_addr  out  ADDR_W  neuron memory address
- mem_we  out  1  neuron memory write strobe
- mem_wdata  out  2*POT_W  {weight, potential}
- mem_rdata  in  2*POT_W  read data, valid exactly 1 cycle after address
- spike_out  out  NUM_NEURONS  spikes of the last completed sweep
- spike_valid  out  1  1-cycle pulse when spike_out updates
- busy  out  1  high when FSM is not IDLE
- overrun  out  1  sticky; set when a tick fires while the sweep is busy
- fsm_state  out  2  debug: current state encoding

Behaviour:
- Reset: every output and register is 0. FSM is IDLE, tick counter is 0, index is 0.
- Tick counter:
  - increments every CLK while enable is high;
  - at TICK_PERIOD-1 it wraps to 0 and raises tick for one cycle;
  - while enable is low it holds its value.
- FSM states: IDLE=0, READ=1, UPDATE=2, DONE=3.
- IDLE:
  - tick → latch spike_in and threshold, set index=0, go to READ;
  - else, if load_valid → one-cycle write: mem_we=1, mem_addr=load_addr, mem_wdata=load_data.
- load_ready is combinational: (state==IDLE) && !tick. On a simultaneous tick and load_valid the tick wins; the loader holds its request until accepted.
- READ: mem_addr=index, mem_we=0, go to UPDATE.
- UPDATE: compute the new potential from mem_rdata = {w, p}:
  - s = p + (spike_in_latched[index] ? w : 0), unsigned, saturating at 2^POT_W-1;
  - s = (s > LEAK) ? s-LEAK : 0;
  - if s >= threshold_latched: fire_vec[index]=1 and s=0.
- UPDATE outputs: mem_we=1, mem_addr=index, mem_wdata={w, s}; the weight is written back unchanged.
- UPDATE next state: if index==NUM_NEURONS-1 go to DONE, else index+1 and go to READ.
- Sweep latency: 2*NUM_NEURONS cycles in READ/UPDATE, then 1 cycle in DONE.
- DONE: spike_out <= fire_vec, spike_valid=1 for this cycle, fire_vec cleared, go to IDLE.
- Overrun: a tick while state != IDLE is dropped and sets overrun, which clears only on RESET.
- Threshold 0 fires every neuron each sweep, with potential written as 0.
- RESET mid-sweep: abort immediately. No further memory writes; spike_out is cleared. Neurons already written keep their memory contents.
- enable deasserted mid-sweep: the current sweep completes; no new ticks occur.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- When defined:
  - a NUM_NEURONS-bit refractory register is set from fire_vec in DONE;
  - during the next sweep, a neuron whose refractory bit is set ignores its spike_in (no weight added); leak still applies;
  - the register clears on RESET.
- When undefined: no refractory register; every sweep integrates all inputs.

Test Plan:
- Reset, then load neuron 3 with {w=0x20, p=0x05} while IDLE → load_ready=1; one mem_we cycle with mem_addr=3, mem_wdata=0x2005.
- TICK_PERIOD=64, enable=1, spike_in=0x08, threshold=0x40, neuron 3 = {0x20, 0x05}:
  - sweep 1 writes 0x2024 to address 3;
  - sweep 2 writes p=0x43 → fires; address 3 becomes 0x2000 and spike_out=0x08 with a 1-cycle spike_valid in DONE;
  - DONE occurs 17 cycles after sweep start.
- Saturation: {w=0xF0, p=0xF0}, spike_in set, threshold=0xFF, LEAK=1 → s saturates to 0xFF, then leak gives 0xFE, no spike.
- Floor: p=0, no input → p stays 0; spike_out bit stays 0.
- Tick coincides with load_valid → load_ready=0 that cycle; the sweep starts; the load is accepted in the first IDLE cycle after DONE.
- TICK_PERIOD=10 with NUM_NEURONS=8 → overrun=1 after the second tick; it stays high until RESET. With LIF_REFRACTORY_EN: a neuron that fired with spike_in held high shows only leak on the next sweep.

Source files
------------

// File: rtl/lif_sweep_scheduler.sv
// lif_sweep_scheduler
//   Shares one leaky-integrate-and-fire datapath across NUM_NEURONS neurons
//   whose {weight, potential} words live in an external single-port
//   synchronous RAM. It owns the tick timer and the sweep FSM, and it
//   arbitrates the RAM between the weight loader and the sweep.
//
//   Optional build macro: LIF_REFRACTORY_EN. When it is defined, a neuron
//   that fired in one sweep ignores its input spike in the next sweep.
//
// Ports
//   CLK, RESET           clock, synchronous active-high reset
//   enable               tick timer runs while high
//   threshold, spike_in  sampled when a sweep starts
//   load_valid/addr/data loader write request; load_ready accepts it
//   mem_addr/we/wdata    neuron RAM command; mem_rdata arrives 1 cycle later
//   spike_out            fire vector of the last completed sweep
//   spike_valid          high during DONE, when spike_out has just updated
//   busy, overrun        FSM not idle; sticky flag for a dropped tick
//   fsm_state            IDLE=0 READ=1 UPDATE=2 DONE=3
module lif_sweep_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3,
  parameter int POT_W       = 8,
  parameter int TICK_PERIOD = 64,
  parameter int LEAK        = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic [POT_W-1:0]       threshold,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   load_valid,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [2*POT_W-1:0]     load_data,
  output logic                   load_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [2*POT_W-1:0]     mem_wdata,
  input  logic [2*POT_W-1:0]     mem_rdata,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   spike_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic [1:0]             fsm_state
);

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [POT_W-1:0] LEAK_V = POT_W'(LEAK);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, UPDATE = 2'd2, DONE = 2'd3} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       tick_cnt;
  logic                   tick;
  logic [ADDR_W-1:0]      idx;
  logic [NUM_NEURONS-1:0] spk_l, fire_vec, fire_next;
  logic [POT_W-1:0]       thr_l;
`ifdef LIF_REFRACTORY_EN
  logic [NUM_NEURONS-1:0] refr;
`endif

  // ---------------- tick timer ----------------
  assign tick = enable && (tick_cnt == CNT_W'(TICK_PERIOD - 1));

  always_ff @(posedge CLK) begin
    if (RESET)       tick_cnt <= '0;
    else if (enable) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // ---------------- LIF datapath ----------------
  logic [POT_W-1:0] w, p, addend, sat, leaked, s_new;
  logic [POT_W:0]   sum;
  logic             add_en, fire;

  always_comb begin
    {w, p} = mem_rdata;
`ifdef LIF_REFRACTORY_EN
    add_en = spk_l[idx] && !refr[idx];
`else
    add_en = spk_l[idx];
`endif
    addend = add_en ? w : '0;
    // one extra bit catches the carry for saturation
    sum    = {1'b0, p} + {1'b0, addend};
    sat    = sum[POT_W] ? '1 : sum[POT_W-1:0];
    leaked = (sat > LEAK_V) ? sat - LEAK_V : '0;
    fire   = (leaked >= thr_l);
    s_new  = fire ? '0 : leaked;
    fire_next = fire_vec | (NUM_NEURONS'(fire) << idx);
  end

  // ---------------- memory port ----------------
  // A tick has priority over the loader; the loader simply retries.
  assign load_ready = !RESET && (state == IDLE) && !tick;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: if (load_valid && load_ready) begin
        mem_we    = 1'b1;
        mem_addr  = load_addr;
        mem_wdata = load_data;
      end
      READ: mem_addr = idx;
      UPDATE: begin
        // RESET aborts the sweep before this cycle's write lands
        mem_we    = !RESET;
        mem_addr  = idx;
        mem_wdata = {w, s_new};
      end
      default: ;
    endcase
  end

  // ---------------- sweep FSM ----------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      idx         <= '0;
      spk_l       <= '0;
      thr_l       <= '0;
      fire_vec    <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      refr        <= '0;
`endif
    end else begin
      spike_valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          spk_l <= spike_in;
          thr_l <= threshold;
          idx   <= '0;
          state <= READ;
        end
        READ: state <= UPDATE;
        UPDATE: begin
          fire_vec <= fire_next;
          if (idx == ADDR_W'(NUM_NEURONS - 1)) begin
            // publish on entry to DONE so spike_out and spike_valid
            // are both visible during the DONE cycle
            spike_out   <= fire_next;
            spike_valid <= 1'b1;
            state       <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= READ;
          end
        end
        DONE: begin
`ifdef LIF_REFRACTORY_EN
          refr <= fire_vec;
`endif
          fire_vec <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
